// File: rtl/trg_pkg.sv
// Shared definitions for the trigger-source scheduler: FSM encoding, source
// bit positions and timing defaults.
package trg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_OFFER    = 2'd2,
        ST_WAIT_ACK = 2'd3
    } trg_state_t;

    localparam int SRC_COIN = 0;
    localparam int SRC_EXT  = 1;
    localparam int SRC_CYC  = 2;

    localparam int CLK_PERIOD_NS     = 20;
    localparam int CYC_UNIT_CNT_DFLT = 50000;

endpackage

// File: rtl/trg_cyc_timer.sv
// Periodic trigger timer: a unit counter divides the clock into period units,
// a tick counter counts units and flags a timeout when it reaches the period.
module trg_cyc_timer
    import trg_pkg::*;
#(
    parameter int CYC_UNIT_CNT = CYC_UNIT_CNT_DFLT
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       enb_in,
    input  logic       clr_in,
    input  logic [7:0] period_in,
    output logic       timeout_out
);

    localparam int UNIT_W = $clog2(CYC_UNIT_CNT);

    logic [UNIT_W-1:0] unit_cnt;
    logic [7:0]        tick_cnt;
    logic              unit_wrap;
    logic              tick_wrap;

    assign unit_wrap   = (unit_cnt == UNIT_W'(CYC_UNIT_CNT - 1));
    assign tick_wrap   = (tick_cnt == period_in - 8'd1);
    assign timeout_out = enb_in & ~clr_in & unit_wrap & tick_wrap;

    // Counters sit at zero whenever the source is disabled, so the first
    // timeout lands a full period after the enable condition appears.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            unit_cnt <= '0;
            tick_cnt <= '0;
        end else if (!enb_in || clr_in) begin
            unit_cnt <= '0;
            tick_cnt <= '0;
        end else if (unit_wrap) begin
            unit_cnt <= '0;
            tick_cnt <= tick_wrap ? 8'd0 : tick_cnt + 8'd1;
        end else begin
            unit_cnt <= unit_cnt + UNIT_W'(1);
        end
    end

endmodule

// File: rtl/trg_src_sched.sv
// Trigger-source scheduler: conditions coincidence/external/cycled sources,
// arbitrates them into one-cycle offers and tracks acceptance and statistics.
module trg_src_sched
    import trg_pkg::*;
#(
    parameter int CYC_UNIT_CNT = CYC_UNIT_CNT_DFLT,
    parameter int ACK_WIN      = 4,
    parameter int STAT_W       = 24
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              run_enb_in,
    input  logic [2:0]        cfg_src_mask_in,
    input  logic [7:0]        cfg_cyc_period_in,
    input  logic [7:0]        cfg_coin_prescale_in,
    input  logic              coincid_raw_in,
    input  logic              ext_trg_syn_in,
    input  logic              eff_trg_in,
    output logic              coincid_trg_out,
    output logic              ext_trg_out,
    output logic              cycled_trg_out,
    output logic              trg_enb_out,
    output logic [15:0]       eff_trg_cnt_out,
    output logic [STAT_W-1:0] raw_trg_cnt_out,
    output logic [STAT_W-1:0] lost_trg_cnt_out
);

    trg_state_t state;
    logic       coin_raw_p1;
    logic [7:0] pc;
    logic [3:0] ack_cnt;
    logic       cyc_pend;
    logic       run_rise, coin_edge, coin_vld, ext_vld, cyc_enb, cyc_to;
    logic       win_cyc, win_ext, win_coin;
    logic [2:0] raw_inc, lost_inc;

    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] acc,
                                                  input logic [2:0]        inc);
        logic [STAT_W:0] sum;
        sum = {1'b0, acc} + {{(STAT_W-2){1'b0}}, inc};
        return sum[STAT_W] ? '1 : sum[STAT_W-1:0];
    endfunction

    assign run_rise  = run_enb_in & ~trg_enb_out;
    assign coin_edge = coincid_raw_in & ~coin_raw_p1 & cfg_src_mask_in[SRC_COIN];
    assign coin_vld  = coin_edge & (pc == cfg_coin_prescale_in);
    assign ext_vld   = ext_trg_syn_in & cfg_src_mask_in[SRC_EXT];
    assign cyc_enb   = run_enb_in & cfg_src_mask_in[SRC_CYC] & (cfg_cyc_period_in != 8'd0);

    trg_cyc_timer #(
        .CYC_UNIT_CNT (CYC_UNIT_CNT)
    ) u_cyc_timer (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .enb_in      (cyc_enb),
        .clr_in      (run_rise),
        .period_in   (cfg_cyc_period_in),
        .timeout_out (cyc_to)
    );

    // A pending cycled trigger always beats a fresh external or coincidence event.
    always_comb begin
        win_cyc  = 1'b0;
        win_ext  = 1'b0;
        win_coin = 1'b0;
        if (state == ST_ARMED) begin
            win_cyc  = cyc_pend;
            win_ext  = ~cyc_pend & ext_vld;
            win_coin = ~cyc_pend & ~ext_vld & coin_vld;
        end
        raw_inc  = {2'b0, coin_vld} + {2'b0, ext_vld} + {2'b0, cyc_to};
        lost_inc = 3'd0;
        if (state != ST_IDLE) begin
            lost_inc = {2'b0, ext_vld & ~win_ext} + {2'b0, coin_vld & ~win_coin}
                     + {2'b0, cyc_to & cyc_pend & ~win_cyc};
            if (state == ST_WAIT_ACK && !eff_trg_in && ack_cnt == 4'(ACK_WIN - 1))
                lost_inc = lost_inc + 3'd1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state            <= ST_IDLE;
            trg_enb_out      <= 1'b0;
            coin_raw_p1      <= 1'b0;
            pc               <= '0;
            ack_cnt          <= '0;
            cyc_pend         <= 1'b0;
            coincid_trg_out  <= 1'b0;
            ext_trg_out      <= 1'b0;
            cycled_trg_out   <= 1'b0;
            eff_trg_cnt_out  <= '0;
            raw_trg_cnt_out  <= '0;
            lost_trg_cnt_out <= '0;
        end else begin
            trg_enb_out     <= run_enb_in;
            coin_raw_p1     <= coincid_raw_in;
            coincid_trg_out <= 1'b0;
            ext_trg_out     <= 1'b0;
            cycled_trg_out  <= 1'b0;
            if (run_rise)
                pc <= '0;
            else if (coin_edge)
                pc <= coin_vld ? 8'd0 : pc + 8'd1;

            if (!run_enb_in) begin
                state    <= ST_IDLE;
                cyc_pend <= 1'b0;
            end else if (run_rise) begin
                state            <= ST_ARMED;
                cyc_pend         <= 1'b0;
                eff_trg_cnt_out  <= '0;
                raw_trg_cnt_out  <= '0;
                lost_trg_cnt_out <= '0;
            end else begin
                eff_trg_cnt_out  <= eff_trg_cnt_out + 16'(eff_trg_in);
                raw_trg_cnt_out  <= sat_add(raw_trg_cnt_out, raw_inc);
                lost_trg_cnt_out <= sat_add(lost_trg_cnt_out, lost_inc);
                cyc_pend         <= (cyc_pend & ~win_cyc) | cyc_to;
                case (state)
                    ST_IDLE: state <= ST_ARMED;
                    ST_ARMED: begin
                        if (win_cyc | win_ext | win_coin) begin
                            state           <= ST_OFFER;
                            cycled_trg_out  <= win_cyc;
                            ext_trg_out     <= win_ext;
                            coincid_trg_out <= win_coin;
                        end
                    end
                    ST_OFFER: begin
                        ack_cnt <= '0;
                        state   <= eff_trg_in ? ST_ARMED : ST_WAIT_ACK;
                    end
                    ST_WAIT_ACK: begin
                        if (eff_trg_in || ack_cnt == 4'(ACK_WIN - 1))
                            state <= ST_ARMED;
                        else
                            ack_cnt <= ack_cnt + 4'd1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trg_src_sched.sv
// Bench for trg_src_sched: directed scenarios plus randomized traffic, all
// checked cycle by cycle against an event-level reference model.
module tb_trg_src_sched;
    import trg_pkg::*;

    localparam int      UNIT = 100;
    localparam int      AW   = 4;
    localparam int      SW   = 24;
    localparam longint  SAT  = (64'd1 << SW) - 1;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          run_enb_in;
    logic [2:0]    cfg_src_mask_in;
    logic [7:0]    cfg_cyc_period_in;
    logic [7:0]    cfg_coin_prescale_in;
    logic          coincid_raw_in;
    logic          ext_trg_syn_in;
    logic          eff_trg_in;
    logic          coincid_trg_out;
    logic          ext_trg_out;
    logic          cycled_trg_out;
    logic          trg_enb_out;
    logic [15:0]   eff_trg_cnt_out;
    logic [SW-1:0] raw_trg_cnt_out;
    logic [SW-1:0] lost_trg_cnt_out;

    always #(CLK_PERIOD_NS / 2) clk_in = ~clk_in;

    trg_src_sched #(
        .CYC_UNIT_CNT (UNIT),
        .ACK_WIN      (AW),
        .STAT_W       (SW)
    ) dut (
        .clk_in               (clk_in),
        .rst_in               (rst_in),
        .run_enb_in           (run_enb_in),
        .cfg_src_mask_in      (cfg_src_mask_in),
        .cfg_cyc_period_in    (cfg_cyc_period_in),
        .cfg_coin_prescale_in (cfg_coin_prescale_in),
        .coincid_raw_in       (coincid_raw_in),
        .ext_trg_syn_in       (ext_trg_syn_in),
        .eff_trg_in           (eff_trg_in),
        .coincid_trg_out      (coincid_trg_out),
        .ext_trg_out          (ext_trg_out),
        .cycled_trg_out       (cycled_trg_out),
        .trg_enb_out          (trg_enb_out),
        .eff_trg_cnt_out      (eff_trg_cnt_out),
        .raw_trg_cnt_out      (raw_trg_cnt_out),
        .lost_trg_cnt_out     (lost_trg_cnt_out)
    );

    int n_vec = 0;
    int n_err = 0;

    // reference model state: m_busy is -1 when free, else cycles since the offer
    bit       m_enb, m_coin_prev, m_pend;
    int       m_pc, m_age, m_busy;
    bit [2:0] m_off;
    int       m_eff;
    longint   m_raw, m_lost;

    bit echo_en, echo_d;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_enb = 0; m_coin_prev = 0; m_pend = 0;
        m_pc = 0; m_age = 0; m_busy = -1; m_off = 3'b000;
        m_eff = 0; m_raw = 0; m_lost = 0;
    endtask

    task automatic model_edge();
        bit run, rise, coin_e, coin_v, ext_v, to, en;
        int raw_i, lost_i, prd;
        run    = run_enb_in;
        rise   = run && !m_enb;
        coin_e = coincid_raw_in && !m_coin_prev && cfg_src_mask_in[0];
        coin_v = coin_e && (m_pc == int'(cfg_coin_prescale_in));
        if (rise) m_pc = 0;
        else if (coin_e) m_pc = coin_v ? 0 : m_pc + 1;
        ext_v = ext_trg_syn_in && cfg_src_mask_in[1];
        prd   = int'(cfg_cyc_period_in) * UNIT;
        en    = run && cfg_src_mask_in[2] && (prd != 0);
        to    = 0;
        if (!en || rise) m_age = 0;
        else begin
            to    = (m_age == prd - 1);
            m_age = (m_age + 1) % prd;
        end
        m_off = 3'b000;
        if (!run) begin
            m_busy = -1; m_pend = 0;
        end else if (rise) begin
            m_busy = -1; m_pend = 0; m_eff = 0; m_raw = 0; m_lost = 0;
        end else begin
            raw_i  = int'(coin_v) + int'(ext_v) + int'(to);
            lost_i = 0;
            if (m_busy < 0) begin
                if (m_pend)      begin m_off = 3'b100; lost_i = int'(ext_v) + int'(coin_v); m_busy = 0; end
                else if (ext_v)  begin m_off = 3'b010; lost_i = int'(coin_v); m_busy = 0; end
                else if (coin_v) begin m_off = 3'b001; m_busy = 0; end
                m_pend = to;
            end else begin
                lost_i = int'(ext_v) + int'(coin_v);
                if (to) begin
                    if (m_pend) lost_i++;
                    m_pend = 1;
                end
                if (eff_trg_in) m_busy = -1;
                else if (m_busy == AW) begin lost_i++; m_busy = -1; end
                else m_busy++;
            end
            m_eff  = (m_eff + int'(eff_trg_in)) % 65536;
            m_raw  = (m_raw + raw_i > SAT) ? SAT : m_raw + raw_i;
            m_lost = (m_lost + lost_i > SAT) ? SAT : m_lost + lost_i;
        end
        m_enb       = run;
        m_coin_prev = coincid_raw_in;
    endtask

    task automatic check_all();
        chk("coin_offer", 64'(coincid_trg_out), 64'(m_off[0]));
        chk("ext_offer",  64'(ext_trg_out),     64'(m_off[1]));
        chk("cyc_offer",  64'(cycled_trg_out),  64'(m_off[2]));
        chk("trg_enb",    64'(trg_enb_out),     64'(m_enb));
        chk("eff_cnt",    64'(eff_trg_cnt_out), 64'(m_eff));
        chk("raw_cnt",    64'(raw_trg_cnt_out), 64'(m_raw));
        chk("lost_cnt",   64'(lost_trg_cnt_out), 64'(m_lost));
    endtask

    task automatic step();
        @(posedge clk_in);
        if (!rst_in) model_edge();
        @(negedge clk_in);
        check_all();
        if (echo_en) begin
            eff_trg_in = echo_d;
            echo_d     = coincid_trg_out | ext_trg_out | cycled_trg_out;
        end
    endtask

    task automatic restart_run(input logic [2:0] mask, input logic [7:0] prd, input logic [7:0] presc);
        run_enb_in = 0; coincid_raw_in = 0; ext_trg_syn_in = 0; eff_trg_in = 0; echo_d = 0;
        cfg_src_mask_in = mask; cfg_cyc_period_in = prd; cfg_coin_prescale_in = presc;
        step();
        run_enb_in = 1;
        step();
    endtask

    initial begin
        int cnt, first_k;
        rst_in = 1; run_enb_in = 0; cfg_src_mask_in = 0; cfg_cyc_period_in = 0;
        cfg_coin_prescale_in = 0; coincid_raw_in = 0; ext_trg_syn_in = 0; eff_trg_in = 0;
        echo_en = 0; echo_d = 0;
        model_reset();
        @(negedge clk_in);
        @(negedge clk_in);
        chk("rst_coin", 64'(coincid_trg_out), 64'd0);
        chk("rst_enb",  64'(trg_enb_out),     64'd0);
        chk("rst_eff",  64'(eff_trg_cnt_out), 64'd0);
        chk("rst_raw",  64'(raw_trg_cnt_out), 64'd0);
        rst_in = 0;

        // coincidence prescale N=3, acked one cycle after each offer
        echo_en = 1;
        restart_run(3'b001, 8'd0, 8'd3);
        cnt = 0;
        for (int e = 0; e < 8; e++) begin
            for (int c = 0; c < 10; c++) begin
                coincid_raw_in = (c < 5);
                step();
                cnt += int'(coincid_trg_out);
            end
        end
        chk("presc_pulses", 64'(cnt), 64'd2);
        chk("presc_raw",  64'(raw_trg_cnt_out),  64'd2);
        chk("presc_eff",  64'(eff_trg_cnt_out),  64'd2);
        chk("presc_lost", 64'(lost_trg_cnt_out), 64'd0);

        // cycled trigger, period 5 units of 100 clocks
        restart_run(3'b100, 8'd5, 8'd0);
        cnt = 0; first_k = -1;
        for (int k = 1; k <= 1600; k++) begin
            step();
            if (cycled_trg_out) begin
                cnt++;
                if (first_k < 0) first_k = k;
            end
        end
        chk("cyc_first",  64'(first_k), 64'd501);
        chk("cyc_pulses", 64'(cnt), 64'd3);
        chk("cyc_lost",   64'(lost_trg_cnt_out), 64'd0);

        // pending cycled trigger collides with external and coincidence
        restart_run(3'b111, 8'd1, 8'd0);
        for (int k = 1; k <= 100; k++) step();
        ext_trg_syn_in = 1; coincid_raw_in = 1;
        step();
        chk("prio_cyc",  64'(cycled_trg_out),  64'd1);
        chk("prio_ext",  64'(ext_trg_out),     64'd0);
        chk("prio_coin", 64'(coincid_trg_out), 64'd0);
        ext_trg_syn_in = 0;
        for (int k = 0; k < 9; k++) step();
        chk("prio_raw",  64'(raw_trg_cnt_out),  64'd3);
        chk("prio_lost", 64'(lost_trg_cnt_out), 64'd2);

        // ack timeout with eff_trg_in held low
        echo_en = 0;
        restart_run(3'b010, 8'd0, 8'd0);
        step();
        ext_trg_syn_in = 1;
        step();
        chk("to_offer", 64'(ext_trg_out), 64'd1);
        ext_trg_syn_in = 0;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 4) chk("to_lost_pre", 64'(lost_trg_cnt_out), 64'd0);
            if (i == 5) chk("to_lost",     64'(lost_trg_cnt_out), 64'd1);
        end
        ext_trg_syn_in = 1;
        step();
        chk("to_rearmed", 64'(ext_trg_out), 64'd1);
        ext_trg_syn_in = 0;
        step();
        step();

        // asynchronous reset while waiting for the ack
        #3 rst_in = 1;
        #1;
        chk("arst_ext",  64'(ext_trg_out),      64'd0);
        chk("arst_enb",  64'(trg_enb_out),      64'd0);
        chk("arst_eff",  64'(eff_trg_cnt_out),  64'd0);
        chk("arst_raw",  64'(raw_trg_cnt_out),  64'd0);
        chk("arst_lost", 64'(lost_trg_cnt_out), 64'd0);
        model_reset();
        @(negedge clk_in);
        rst_in = 0;
        step();

        // randomized traffic with occasional run drops
        for (int blk = 0; blk < 6; blk++) begin
            restart_run(3'($urandom_range(1, 7)), 8'($urandom_range(0, 2)), 8'($urandom_range(0, 3)));
            for (int c = 0; c < 500; c++) begin
                if ($urandom_range(0, 3) == 0) coincid_raw_in = ~coincid_raw_in;
                ext_trg_syn_in = ($urandom_range(0, 7) == 0);
                eff_trg_in     = (m_busy >= 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
                run_enb_in     = ($urandom_range(0, 199) != 0);
                step();
            end
        end

        // run restart clears the statistics
        restart_run(3'b000, 8'd0, 8'd0);
        chk("rst_run_eff",  64'(eff_trg_cnt_out),  64'd0);
        chk("rst_run_raw",  64'(raw_trg_cnt_out),  64'd0);
        chk("rst_run_lost", 64'(lost_trg_cnt_out), 64'd0);

        // trigger ID wrap
        eff_trg_in = 1;
        for (int i = 0; i < 65535; i++) step();
        chk("id_max", 64'(eff_trg_cnt_out), 64'hFFFF);
        step();
        chk("id_wrap", 64'(eff_trg_cnt_out), 64'd0);
        step();
        chk("id_post", 64'(eff_trg_cnt_out), 64'd1);
        restart_run(3'b000, 8'd0, 8'd0);
        chk("id_restart", 64'(eff_trg_cnt_out), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/trg_src_sched.md
Name: trg_src_sched

Overview:
- Trigger-source scheduler that sits upstream of the trigger output controller.
- Prescales the coincidence trigger, generates the periodic (cycled) trigger, arbitrates the three sources into single-cycle offers and tracks acceptance via the controller's effective-trigger pulse.
- Maintains the trigger ID counter fed back to the output controller, plus raw and lost statistics read by housekeeping.
- System clock 50 MHz.

Parameters:
- CYC_UNIT_CNT, 50000, clocks per cycled-trigger period unit (1 ms at 50 MHz).
- ACK_WIN, 4, max cycles spent in WAIT_ACK waiting for eff_trg_in; legal range 2..15.
- STAT_W, 24, width of the raw and lost statistic counters.

Ports:
- clk_in  in  1  system clock, 50 MHz.
- rst_in  in  1  reset, asynchronous, active-high.
- run_enb_in  in  1  run enable; low holds the block idle.
- cfg_src_mask_in  in  3  source enables: bit0 coincidence, bit1 external, bit2 cycled.
- cfg_cyc_period_in  in  8  cycled-trigger period in CYC_UNIT_CNT units; 0 disables the cycled source.
- cfg_coin_prescale_in  in  8  N: pass one of every N+1 coincidence edges.
- coincid_raw_in  in  1  coincidence level, already synchronous.
- ext_trg_syn_in  in  1  external trigger, already synchronised, one-cycle pulse.
- eff_trg_in  in  1  effective-trigger pulse from the output controller.
- coincid_trg_out  out  1  one-cycle coincidence offer.
- ext_trg_out  out  1  one-cycle external offer.
- cycled_trg_out  out  1  one-cycle cycled offer.
- trg_enb_out  out  1  registered copy of run_enb_in.
- eff_trg_cnt_out  out  16  trigger ID.
- raw_trg_cnt_out  out  STAT_W  source events seen while running.
- lost_trg_cnt_out  out  STAT_W  events not accepted.

Behaviour:
Reset and run control
- On reset, all outputs and counters are 0 and the FSM is in IDLE.
- run_rise = run_enb_in high while trg_enb_out is low. On run_rise, eff/raw/lost counters clear, the prescaler and cycled timer clear, and the pending flag clears.

Source conditioning (all outputs registered)
- Coincidence: rising edge of coincid_raw_in against a registered copy. Each edge with mask bit0 set advances prescale counter pc. When pc == cfg_coin_prescale_in, the event is valid and pc returns to 0; otherwise pc increments. N = 0 passes every edge.
- External: ext_trg_syn_in high with mask bit1 set is a valid event.
- Cycled timer: runs only when run_enb_in is high, mask bit2 is set and period is non-zero; otherwise its counters are held at 0. The unit counter runs 0..CYC_UNIT_CNT-1 and produces a tick at wrap. The tick counter counts ticks; when it reaches cfg_cyc_period_in it returns to 0 and sets the cyc_pend flag. The first cycled event occurs period*CYC_UNIT_CNT cycles after the enable condition becomes true.
- raw_trg_cnt_out increments once for each valid coincidence event, external event and cycled timeout while running. It adds 0..3 per cycle and saturates at all-ones.

FSM states: IDLE, ARMED, OFFER, WAIT_ACK
- IDLE: all offers 0. Go to ARMED when run_enb_in is high.
- ARMED: fixed priority cycled (cyc_pend) > external > coincidence.
  - The winner's output is registered high for exactly one cycle (that cycle is OFFER); cyc_pend clears if cycled wins.
  - Simultaneous losing external/coincidence events are dropped and counted lost.
  - With no event, stay in ARMED.
- OFFER: offer outputs return to 0 and the ack counter is cleared. If eff_trg_in is high, go to ARMED; else go to WAIT_ACK.
- WAIT_ACK: the ack counter increments each cycle.
  - eff_trg_in high: go to ARMED with the offer accepted.
  - Ack counter reaches ACK_WIN-1 without ack: lost +1, go to ARMED.
- External or coincidence events arriving in OFFER or WAIT_ACK are dropped and counted lost. Cycled timeouts in those states only set cyc_pend; a second timeout while cyc_pend is already set counts lost +1.
- lost_trg_cnt_out adds the per-cycle sum (up to 3) and saturates.
- run_enb_in low in any state: next state IDLE, offers forced 0, cyc_pend cleared, no lost increment for an in-flight offer.

Trigger ID
- eff_trg_cnt_out increments on every eff_trg_in pulse while run_enb_in is high, in any state. It wraps 0xFFFF -> 0x0000.
- The trigger-ID check pulse downstream keys on bits [11:0] == 0.

Timing
- Latency from source input to offer output is 1 clock. The winner's offer is visible the cycle after the event.

Decomposition:
- Shared package trg_pkg holds:
  - FSM state encoding (2-bit).
  - Source bit indices SRC_COIN=0, SRC_EXT=1, SRC_CYC=2.
  - CLK_PERIOD_NS=20.
  - Default CYC_UNIT_CNT=50000.
- One natural sub-module, trg_cyc_timer: unit counter, tick counter, period compare and timeout pulse. It takes enable, period and a clear input.

Test Plan:
- Reset mid-run: assert rst_in asynchronously while in WAIT_ACK -> offers 0 and all counters 0 immediately, without a clock edge; FSM is IDLE.
- Coincidence prescale: N=3, 8 coincidence edges spaced 10 cycles apart, ack 1 cycle after each offer -> 2 coincid_trg_out pulses (edges 4 and 8), raw=2, eff=2, lost=0.
- Cycled trigger: CYC_UNIT_CNT=100, period=5, mask=3'b100, eff_trg_in echoed 1 cycle after each offer -> cycled_trg_out every 500 cycles, first pulse at cycle 501 after run start; 3 pulses within 1600 cycles.
- Priority and collision: cyc_pend set, with ext and coincidence events in the same ARMED cycle -> cycled_trg_out only; lost +2; raw +3 over the sequence.
- Ack timeout: ACK_WIN=4, eff_trg_in tied low, one external pulse -> one ext_trg_out pulse; lost=1 four cycles after OFFER; FSM back in ARMED.
- ID wrap and run restart: preload via 65536 ack pulses -> eff_trg_cnt_out wraps 0xFFFF -> 0x0000; drop then raise run_enb_in -> all counters return to 0 one cycle after the rise.
